// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: accepts two WIDTH-bit operands plus a carry-in over a
//   valid/ready handshake, adds them one bit per clock (LSB first) through a
//   single full-adder slice with a registered carry, and presents the sum,
//   carry-out and signed-overflow flag over a second valid/ready handshake.
//
// Ports
//   iClk      in   1      clock, rising edge
//   iRst      in   1      synchronous active-high reset
//   iValid    in   1      operand valid
//   oReady    out  1      block can accept operands (IDLE)
//   iA        in   WIDTH  operand A
//   iB        in   WIDTH  operand B
//   iCarry    in   1      carry-in
//   oValid    out  1      result valid (DONE)
//   iReady    in   1      downstream accepts result
//   oSum      out  WIDTH  A + B + carry-in, modulo 2^WIDTH
//   oCarry    out  1      carry out of the MSB
//   oOverflow out  1      signed overflow (carry into MSB ^ carry out of MSB)
//
// All outputs come from registers or are decoded from the registered state;
// no input reaches an output combinationally.

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCarry,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oSum,
  output logic             oCarry,
  output logic             oOverflow
);

  // Counter must hold 0..WIDTH; at least one bit even for WIDTH = 1.
  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  // Full-adder slice on the current LSBs and the registered carry.
  logic bit_s;
  logic bit_c;

  always_comb begin
    bit_s = a_q[0] ^ b_q[0] ^ c_q;
    bit_c = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & c_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (iValid) begin
          a_d     = iA;
          b_d     = iB;
          c_d     = iCarry;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Shift-then-overwrite keeps this legal for WIDTH = 1, where a
        // concatenation with sum_q[WIDTH-1:1] would be an empty slice.
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = bit_s;
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        c_d              = bit_c;
        cnt_d            = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // c_q is the carry into the MSB on this last slice.
          carry_d = bit_c;
          ovf_d   = c_q ^ bit_c;
          state_d = DONE;
        end
      end

      DONE: begin
        if (iReady) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oReady    = (state_q == IDLE);
  assign oValid    = (state_q == DONE);
  assign oSum      = sum_q;
  assign oCarry    = carry_q;
  assign oOverflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: one WIDTH=8 and one WIDTH=1 instance sharing
// clock and reset, exercised with directed vectors and a random regression
// checked against an arithmetic reference model.

module tb_serial_adder;

  logic clk;
  logic rst;

  logic       v8, r8_in, rdy8, ov8, co8, of8;
  logic [7:0] a8, b8, s8;
  logic       c8;

  logic       v1, r1_in, rdy1, ov1, co1, of1;
  logic       a1, b1, s1;
  logic       c1;

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .iClk(clk), .iRst(rst), .iValid(v8), .oReady(rdy8), .iA(a8), .iB(b8),
    .iCarry(c8), .oValid(ov8), .iReady(r8_in), .oSum(s8), .oCarry(co8),
    .oOverflow(of8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .iClk(clk), .iRst(rst), .iValid(v1), .oReady(rdy1), .iA(a1), .iB(b1),
    .iCarry(c1), .oValid(ov1), .iReady(r1_in), .oSum(s1), .oCarry(co1),
    .oOverflow(of1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(input int w);
    return (w == 8) ? rdy8 : rdy1;
  endfunction

  function automatic logic get_ov(input int w);
    return (w == 8) ? ov8 : ov1;
  endfunction

  function automatic logic [31:0] get_sum(input int w);
    return (w == 8) ? {24'b0, s8} : {31'b0, s1};
  endfunction

  function automatic logic get_co(input int w);
    return (w == 8) ? co8 : co1;
  endfunction

  function automatic logic get_of(input int w);
    return (w == 8) ? of8 : of1;
  endfunction

  task automatic set_in(input int w, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic c);
    if (w == 8) begin
      v8 = v; a8 = a[7:0]; b8 = b[7:0]; c8 = c;
    end else begin
      v1 = v; a1 = a[0]; b1 = b[0]; c1 = c;
    end
  endtask

  task automatic set_ordy(input int w, input logic r);
    if (w == 8) r8_in = r;
    else        r1_in = r;
  endtask

  // Reference: plain integer addition for sum/carry; overflow as the
  // signed result falling outside the w-bit two's-complement range.
  task automatic ref_add(input int w, input longint a, input longint b, input longint cin,
                         output logic [31:0] s, output logic co, output logic ov);
    longint modv, half, total, sa, sb, st;
    modv  = longint'(1) << w;
    half  = longint'(1) << (w - 1);
    total = a + b + cin;
    s     = 32'(total % modv);
    co    = (total >= modv);
    sa    = (a >= half) ? a - modv : a;
    sb    = (b >= half) ? b - modv : b;
    st    = sa + sb + cin;
    ov    = (st > half - 1) || (st < -half);
  endtask

  // One full transaction. Returns the observed result for extra directed
  // checks; always checks it against the reference model.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input int pre_stall, input int hold,
                       input bit inject, input bit early_ready,
                       output logic [31:0] rs, output logic rc, output logic rv);
    int n;
    logic [31:0] es;
    logic ec, ev;

    set_ordy(w, early_ready && (hold == 0));
    for (int i = 0; i < pre_stall; i++) begin
      set_in(w, 1'b0, a, b, cin);
      tick();
    end
    set_in(w, 1'b1, a, b, cin);
    n = 0;
    while (!get_rdy(w) && n < 200) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(n < 200), 32'd1);
    tick();  // accept edge
    set_in(w, 1'b0, 32'h0, 32'h0, 1'b0);
    check("busy_after_accept", 32'(get_rdy(w)), 32'd0);

    n = 0;
    while (!get_ov(w) && n < 200) begin
      if (inject && n == 1) set_in(w, 1'b1, 32'h11, 32'h11, 1'b1);
      else                  set_in(w, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      n++;
    end
    set_in(w, 1'b0, 32'h0, 32'h0, 1'b0);
    check("latency", 32'(n), 32'(w));
    rs = get_sum(w);
    rc = get_co(w);
    rv = get_of(w);

    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(get_ov(w)), 32'd1);
      check("hold_ready", 32'(get_rdy(w)), 32'd0);
      check("hold_sum", get_sum(w), rs);
      check("hold_carry", 32'(get_co(w)), 32'(rc));
      check("hold_ovf", 32'(get_of(w)), 32'(rv));
    end
    set_ordy(w, 1'b1);
    tick();
    set_ordy(w, 1'b0);
    check("valid_drops", 32'(get_ov(w)), 32'd0);
    check("ready_returns", 32'(get_rdy(w)), 32'd1);

    ref_add(w, longint'(a), longint'(b), longint'(cin), es, ec, ev);
    check("model_sum", rs, es);
    check("model_carry", 32'(rc), 32'(ec));
    check("model_ovf", 32'(rv), 32'(ev));
  endtask

  initial begin
    logic [31:0] rs;
    logic rc, rv;
    logic [31:0] ra, rb;
    logic rcin;

    checks   = 0;
    failures = 0;
    rst = 1'b1;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0; r8_in = 0;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0; r1_in = 0;

    tick();
    tick();
    rst = 1'b0;
    check("rst_ready8", 32'(rdy8), 32'd1);
    check("rst_valid8", 32'(ov8), 32'd0);
    check("rst_sum8", 32'(s8), 32'd0);
    check("rst_carry8", 32'(co8), 32'd0);
    check("rst_ovf8", 32'(of8), 32'd0);
    check("rst_ready1", 32'(rdy1), 32'd1);
    check("rst_valid1", 32'(ov1), 32'd0);

    // Directed vectors, WIDTH = 8.
    do_op(8, 32'h5A, 32'h3C, 1'b0, 0, 0, 1'b0, 1'b0, rs, rc, rv);
    check("d_5a3c_sum", rs, 32'h96);
    check("d_5a3c_carry", 32'(rc), 32'd0);
    check("d_5a3c_ovf", 32'(rv), 32'd1);

    do_op(8, 32'hFF, 32'h01, 1'b0, 1, 0, 1'b0, 1'b0, rs, rc, rv);
    check("d_ff01_sum", rs, 32'h00);
    check("d_ff01_carry", 32'(rc), 32'd1);
    check("d_ff01_ovf", 32'(rv), 32'd0);

    do_op(8, 32'hFF, 32'hFF, 1'b1, 0, 0, 1'b0, 1'b0, rs, rc, rv);
    check("d_ffff1_sum", rs, 32'hFF);
    check("d_ffff1_carry", 32'(rc), 32'd1);
    check("d_ffff1_ovf", 32'(rv), 32'd0);

    // Backpressure of 5 cycles plus an iValid pulse (iA=0x11) during SHIFT.
    do_op(8, 32'h12, 32'h34, 1'b0, 0, 5, 1'b1, 1'b0, rs, rc, rv);
    check("d_bp_sum", rs, 32'h46);
    check("d_bp_carry", 32'(rc), 32'd0);

    do_op(8, 32'h80, 32'h80, 1'b0, 0, 0, 1'b0, 1'b0, rs, rc, rv);
    check("d_8080_sum", rs, 32'h00);
    check("d_8080_carry", 32'(rc), 32'd1);
    check("d_8080_ovf", 32'(rv), 32'd1);

    // Abort an operation with the counter at 4.
    set_in(8, 1'b1, 32'hC3, 32'h5A, 1'b1);
    tick();  // accept, counter = 0
    set_in(8, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", 32'(ov8), 32'd0);
    check("abort_ready", 32'(rdy8), 32'd1);
    check("abort_sum", 32'(s8), 32'd0);
    check("abort_carry", 32'(co8), 32'd0);
    check("abort_ovf", 32'(of8), 32'd0);

    do_op(8, 32'h01, 32'h02, 1'b1, 0, 0, 1'b0, 1'b0, rs, rc, rv);
    check("d_post_abort_sum", rs, 32'h04);
    check("d_post_abort_carry", 32'(rc), 32'd0);

    // Directed vectors, WIDTH = 1.
    do_op(1, 32'h1, 32'h1, 1'b1, 0, 0, 1'b0, 1'b0, rs, rc, rv);
    check("w1_111", {rs[0], rc, rv}, 32'b110);
    do_op(1, 32'h1, 32'h0, 1'b1, 0, 0, 1'b0, 1'b0, rs, rc, rv);
    check("w1_101", {rs[0], rc, rv}, 32'b010);
    do_op(1, 32'h0, 32'h0, 1'b1, 0, 2, 1'b0, 1'b0, rs, rc, rv);
    check("w1_001", {rs[0], rc, rv}, 32'b101);

    // Random regression with handshake stalls on both sides.
    for (int i = 0; i < 1000; i++) begin
      ra   = 32'($urandom_range(0, 255));
      rb   = 32'($urandom_range(0, 255));
      rcin = 1'($urandom_range(0, 1));
      do_op(8, ra, rb, rcin, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), rs, rc, rv);
    end
    for (int i = 0; i < 1000; i++) begin
      ra   = 32'($urandom_range(0, 1));
      rb   = 32'($urandom_range(0, 1));
      rcin = 1'($urandom_range(0, 1));
      do_op(1, ra, rb, rcin, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'b0, bit'($urandom_range(0, 1)), rs, rc, rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that takes two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Processes one bit per clock, LSB first, through a single full-adder bit slice and a registered carry.
- Returns the WIDTH-bit sum, carry-out and signed-overflow flag over a second valid/ready handshake.
- Sits downstream of operand sourcing logic. It is the area-minimal alternative to a ripple chain of full-adder cells.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRst  input  1  synchronous, active-high reset.
- iValid  input  1  operand handshake valid.
- oReady  output  1  block can accept operands.
- iA  input  WIDTH  operand A, unsigned or two's complement.
- iB  input  WIDTH  operand B.
- iCarry  input  1  carry-in.
- oValid  output  1  result handshake valid.
- iReady  input  1  downstream accepts result.
- oSum  output  WIDTH  A + B + carry-in, modulo 2^WIDTH.
- oCarry  output  1  carry out of the MSB.
- oOverflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface:
  - One clock, iClk. Reset iRst is synchronous and active-high.
  - All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- States: IDLE, SHIFT, DONE.
  - oReady = (state == IDLE).
  - oValid = (state == DONE).
- Reset:
  - While iRst is high at a rising edge: state becomes IDLE and oSum, oCarry, oOverflow, the shift registers, the carry register and the bit counter are cleared to 0.
  - Reset has priority over every other event, including an accept or a result handshake in the same cycle. iValid is ignored at that edge.
  - After reset: oReady = 1, oValid = 0.
- IDLE:
  - On an edge with iValid & oReady: latch iA and iB into shift registers A and B, carry register C <= iCarry, counter <= 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, at each edge:
  - Bit slice: s = A[0] ^ B[0] ^ C; c = (A[0] & B[0]) | ((A[0] ^ B[0]) & C).
  - Sum register shifts right with s entering the MSB.
  - A and B shift right by 1. C <= c. Counter increments.
  - On the edge where counter == WIDTH-1 (the last bit):
    - capture oCarry <= c.
    - capture oOverflow <= C ^ c, where C is the carry into the MSB.
    - go to DONE.
  - iValid, iA, iB and iCarry are ignored in SHIFT.
- Latency:
  - oValid rises exactly WIDTH edges after the accept edge.
  - Minimum spacing between accepted operand sets is WIDTH+2 cycles.
- DONE:
  - oSum, oCarry and oOverflow are held stable for as long as iReady is low (unbounded backpressure).
  - On an edge with iReady high: go to IDLE.
  - New operands cannot be accepted in the same edge as the result handshake; oReady is 0 in DONE.
- Boundary conditions:
  - WIDTH = 1: a single SHIFT cycle, with oOverflow = carry-in XOR carry-out.
  - Counter width is clog2(WIDTH+1) with a minimum of 1 bit. It never wraps within an operation.
  - The sum register is observable on oSum only in DONE. Its value in IDLE and SHIFT is don't-care to the consumer but must not glitch oValid.
- Reset mid-operation (any state): abandon the operation and follow the reset rule above. The next operation must be unaffected by the abandoned one.

Test Plan:
- Reset release, then iA=0x5A, iB=0x3C, iCarry=0, WIDTH=8 -> oValid high exactly 8 edges after accept; oSum=0x96, oCarry=0, oOverflow=1.
- iA=0xFF, iB=0x01, iCarry=0 -> oSum=0x00, oCarry=1, oOverflow=0. Then iA=0xFF, iB=0xFF, iCarry=1 -> oSum=0xFF, oCarry=1, oOverflow=0.
- iA=0x80, iB=0x80, iCarry=0 -> oSum=0x00, oCarry=1, oOverflow=1.
- Hold iReady low for 5 cycles in DONE -> oValid, oSum, oCarry and oOverflow unchanged each cycle and oReady=0. Pulse iValid with iA=0x11 during SHIFT -> ignored; the in-flight result is unaffected.
- Assert iRst for one edge while the counter is at 4 -> next cycle oValid=0, oReady=1, outputs 0. Then iA=0x01, iB=0x02, iCarry=1 -> oSum=0x04, oCarry=0.
- Random regression, 1000 operand sets with random iValid/iReady stalls, WIDTH=8 and WIDTH=1 -> every result matches the reference {carry, sum} = A + B + Cin and the overflow model; no result is lost or duplicated.
